// File: rtl/register_write_controller.sv
// register_write_controller
//   SPI (mode 0) slave that assembles 24-bit register-write frames
//   ({number[15:0], value[7:0]}, MSB first), queues them in a small FIFO and
//   issues one single-cycle write strobe per queued frame. A status byte
//   {overflow, frame_error, 0, fifo_level} is shifted out on MISO at the start
//   of every CS_N-low window; both sticky flags clear when it is loaded.
//
// Ports:
//   i_Clock, i_Reset          system clock, synchronous active-high reset
//   i_SPI_SCK/CS_N/MOSI       host SPI inputs, asynchronous to i_Clock
//   i_IssueStall              test hook: holds the issuer (no pops) while high
//   o_SPI_MISO                status bits, 0 outside an active CS_N window
//   o_RegisterWriteEnable     one-cycle write strobe
//   o_RegisterWriteNumber     16-bit register number (passed through)
//   o_RegisterWriteValue      8-bit write data
//   o_FifoLevel               queued frame count
//   o_Overflow, o_FrameError  sticky status flags (clear-on-read)
module register_write_controller #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SPI_SCK,
  input  logic        i_SPI_CS_N,
  input  logic        i_SPI_MOSI,
  input  logic        i_IssueStall,
  output logic        o_SPI_MISO,
  output logic        o_RegisterWriteEnable,
  output logic [15:0] o_RegisterWriteNumber,
  output logic [7:0]  o_RegisterWriteValue,
  output logic [4:0]  o_FifoLevel,
  output logic        o_Overflow,
  output logic        o_FrameError
);

  localparam int         PW      = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t state, state_n;

  logic [1:0]  sck_sy, cs_sy, mosi_sy;
  logic        sck_prev, cs_prev;
  logic [1:0]  warm;
  logic [4:0]  bit_cnt;
  logic [23:0] shift;
  logic [7:0]  miso_sr;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [23:0] mem [FIFO_DEPTH];

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic bit_in, push_req, push_ok, pop, drop, frame_err_evt, status_load;
  logic [23:0] frame_in;

  assign sck_s  = sck_sy[1];
  assign cs_s   = cs_sy[1];
  assign mosi_s = mosi_sy[1];

  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  assign bit_in        = (state == ACTIVE) && !cs_rise && sck_rise;
  assign push_req      = bit_in && (bit_cnt == 5'd23);
  assign frame_in      = {shift[22:0], mosi_s};
  assign pop           = (o_FifoLevel != '0) && !i_IssueStall;
  assign push_ok       = push_req && ((o_FifoLevel < DEPTH_L) || pop);
  assign drop          = push_req && !push_ok;
  assign frame_err_evt = (state == ACTIVE) && cs_rise && (bit_cnt != '0);
  assign status_load   = (state == ARMED) && cs_fall;

  assign o_SPI_MISO = (state == ACTIVE) && miso_sr[7];

  // The synchronizer reset values (CS_N high) are not real observations, so
  // IDLE waits until live samples have reached the edge-detect register
  // before trusting a high CS_N. Otherwise a reset taken while CS_N is held
  // low would look like a fresh falling edge and re-open the frame.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (warm == 2'd3 && cs_s) state_n = ARMED;
      ARMED:   if (cs_fall)              state_n = ACTIVE;
      ACTIVE:  if (cs_rise)              state_n = ARMED;
      default:                           state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= IDLE;
      sck_sy   <= '0;
      cs_sy    <= '1;
      mosi_sy  <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
      warm     <= '0;
    end else begin
      state    <= state_n;
      sck_sy   <= {sck_sy[0], i_SPI_SCK};
      cs_sy    <= {cs_sy[0], i_SPI_CS_N};
      mosi_sy  <= {mosi_sy[0], i_SPI_MOSI};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if ((state == ACTIVE) && cs_rise) begin
      bit_cnt <= '0;
    end else if (bit_in) begin
      shift   <= frame_in;
      bit_cnt <= (bit_cnt == 5'd23) ? '0 : bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr] <= frame_in;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      o_FifoLevel           <= '0;
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterWriteNumber <= '0;
      o_RegisterWriteValue  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   o_FifoLevel <= o_FifoLevel + 5'd1;
        2'b01:   o_FifoLevel <= o_FifoLevel - 5'd1;
        default: o_FifoLevel <= o_FifoLevel;
      endcase
      o_RegisterWriteEnable <= pop;
      if (pop) begin
        o_RegisterWriteNumber <= mem[rd_ptr][23:8];
        o_RegisterWriteValue  <= mem[rd_ptr][7:0];
      end
    end
  end

  // A flag-setting event in the load cycle wins over the clear, so it is
  // reported in the following status byte.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      miso_sr      <= '0;
      o_Overflow   <= 1'b0;
      o_FrameError <= 1'b0;
    end else begin
      if (status_load)
        miso_sr <= {o_Overflow, o_FrameError, 1'b0, o_FifoLevel};
      else if ((state == ACTIVE) && sck_fall)
        miso_sr <= {miso_sr[6:0], 1'b0};
      o_Overflow   <= (o_Overflow & ~status_load) | drop;
      o_FrameError <= (o_FrameError & ~status_load) | frame_err_evt;
    end
  end

endmodule

// File: tb/tb_register_write_controller.sv
// Bench for register_write_controller: two instances (FIFO_DEPTH 4 and 2)
// share one SPI bus, reset and issuer stall; each has its own scoreboard
// queue of expected write frames.
module tb_register_write_controller;

  logic clk = 1'b0;
  logic rst, sck, cs_n, mosi, stall;

  logic        miso4, we4, ovf4, ferr4;
  logic [15:0] num4;
  logic [7:0]  val4;
  logic [4:0]  lvl4;
  logic        miso2, we2, ovf2, ferr2;
  logic [15:0] num2;
  logic [7:0]  val2;
  logic [4:0]  lvl2;

  logic [23:0] q4[$];
  logic [23:0] q2[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned max_lvl4 = 0;

  always #5 clk = ~clk;

  register_write_controller #(.FIFO_DEPTH(4)) u4 (
    .i_Clock(clk), .i_Reset(rst), .i_SPI_SCK(sck), .i_SPI_CS_N(cs_n),
    .i_SPI_MOSI(mosi), .i_IssueStall(stall), .o_SPI_MISO(miso4),
    .o_RegisterWriteEnable(we4), .o_RegisterWriteNumber(num4),
    .o_RegisterWriteValue(val4), .o_FifoLevel(lvl4), .o_Overflow(ovf4),
    .o_FrameError(ferr4));

  register_write_controller #(.FIFO_DEPTH(2)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_SPI_SCK(sck), .i_SPI_CS_N(cs_n),
    .i_SPI_MOSI(mosi), .i_IssueStall(stall), .o_SPI_MISO(miso2),
    .o_RegisterWriteEnable(we2), .o_RegisterWriteNumber(num2),
    .o_RegisterWriteValue(val2), .o_FifoLevel(lvl2), .o_Overflow(ovf2),
    .o_FrameError(ferr2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (32'(lvl4) > max_lvl4) max_lvl4 = 32'(lvl4);
      if (we4) begin
        if (q4.size() == 0) check("u4_unexpected_write", {num4, val4}, 32'hFFFF_FFFF);
        else begin
          logic [23:0] e;
          e = q4.pop_front();
          check("u4_write", {num4, val4}, e);
        end
      end
      if (we2) begin
        if (q2.size() == 0) check("u2_unexpected_write", {num2, val2}, 32'hFFFF_FFFF);
        else begin
          logic [23:0] e;
          e = q2.pop_front();
          check("u2_write", {num2, val2}, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  // Sends the top n bits of d, MSB first, SCK = clk/8. MISO is sampled just
  // before each rising edge. mode 1: latency check on the last bit;
  // mode 2: release the stall so the issuer pops on the push edge.
  task automatic send_bits(input logic [23:0] d, input int n, input int mode,
                           output logic [23:0] cap4, output logic [23:0] cap2);
    cap4 = '0;
    cap2 = '0;
    for (int i = 0; i < n; i++) begin
      mosi = d[23-i];
      tick(4);
      cap4 = {cap4[22:0], miso4};
      cap2 = {cap2[22:0], miso2};
      sck = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick(1);
        if (i == n - 1 && mode == 1 && k == 2) check("latency_edge3_we", we4, 1'b0);
        if (i == n - 1 && mode == 1 && k == 3) check("latency_edge4_we", we4, 1'b1);
        if (i == n - 1 && mode == 2 && k == 0) check("full_before_push_lvl2", lvl2, 5'd2);
        if (i == n - 1 && mode == 2 && k == 1) stall = 1'b0;
        if (i == n - 1 && mode == 2 && k == 2) begin
          check("full_push_pop_lvl2", lvl2, 5'd2);
          check("full_push_pop_ovf2", ovf2, 1'b0);
        end
      end
      sck = 1'b0;
    end
  endtask

  task automatic frame_both(input logic [23:0] d, input int mode,
                            output logic [23:0] c4, output logic [23:0] c2);
    q4.push_back(d);
    q2.push_back(d);
    send_bits(d, 24, mode, c4, c2);
  endtask

  logic [23:0] c4, c2;
  logic [23:0] stream [6] = '{24'h0102_03, 24'h8040_AA, 24'hFFFF_00,
                              24'h0000_FF, 24'h1234_56, 24'hC3A5_5A};

  initial begin
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; stall = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);
    check("rst_we", we4, 1'b0);
    check("rst_num", num4, 16'h0);
    check("rst_val", val4, 8'h0);
    check("rst_lvl", lvl4, 5'd0);
    check("rst_ovf", ovf4, 1'b0);
    check("rst_ferr", ferr4, 1'b0);
    check("rst_miso", miso4, 1'b0);
    tick(6);

    // Single frame with latency check.
    cs_low();
    frame_both(24'hC005_7F, 1, c4, c2);
    cs_high();
    check("t1_status", c4[23:16], 8'h00);
    tick(10);

    // Six frames streamed under one CS_N.
    cs_low();
    for (int f = 0; f < 6; f++) frame_both(stream[f], 0, c4, c2);
    cs_high();
    tick(10);
    check("stream_ovf4", ovf4, 1'b0);
    check("stream_lvl4", lvl4, 5'd0);

    // Depth-2 full, third push coincides with the first pop.
    stall = 1'b1;
    cs_low();
    frame_both(24'hA1A1_01, 0, c4, c2);
    frame_both(24'hB2B2_02, 0, c4, c2);
    frame_both(24'hC3C3_03, 2, c4, c2);
    cs_high();
    tick(10);
    check("boundary_lvl2", lvl2, 5'd0);

    // Stalled issuer: depth-2 instance drops the third frame.
    stall = 1'b1;
    cs_low();
    q4.push_back(24'hD4D4_04); q2.push_back(24'hD4D4_04);
    send_bits(24'hD4D4_04, 24, 0, c4, c2);
    q4.push_back(24'hE5E5_05); q2.push_back(24'hE5E5_05);
    send_bits(24'hE5E5_05, 24, 0, c4, c2);
    q4.push_back(24'hF6F6_06);
    send_bits(24'hF6F6_06, 24, 0, c4, c2);
    cs_high();
    check("stall_ovf2", ovf2, 1'b1);
    check("stall_ovf4", ovf4, 1'b0);
    check("stall_lvl2", lvl2, 5'd2);
    check("stall_lvl4", lvl4, 5'd3);
    stall = 1'b0;
    tick(10);
    cs_low();
    check("ovf2_cleared", ovf2, 1'b0);
    frame_both(24'h7777_07, 0, c4, c2);
    cs_high();
    check("ovf_status_u2", c2[23:16], 8'h80);
    check("ovf_status_u4", c4[23:16], 8'h00);
    tick(10);

    // CS_N raised after 13 bits.
    cs_low();
    send_bits(24'h1234_56, 13, 0, c4, c2);
    cs_high();
    check("ferr_set", ferr4, 1'b1);
    check("ferr_lvl", lvl4, 5'd0);
    cs_low();
    frame_both(24'h4242_42, 0, c4, c2);
    cs_high();
    check("ferr_status", c4[23:16], 8'h40);
    check("ferr_status_tail", c4[15:0], 16'h0);
    check("ferr_cleared", ferr4, 1'b0);
    tick(10);

    // Reset mid-frame with CS_N held low.
    cs_low();
    send_bits(24'hABCD_EF, 10, 0, c4, c2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    send_bits(24'h3C3C_3C, 14, 0, c4, c2);
    cs_high();
    tick(10);
    check("rst_mid_lvl", lvl4, 5'd0);
    check("rst_mid_ferr", ferr4, 1'b0);
    cs_low();
    frame_both(24'h5A5A_A5, 0, c4, c2);
    cs_high();
    tick(20);

    check("q4_drained", q4.size(), 0);
    check("q2_drained", q2.size(), 0);
    check("max_lvl4_le4", max_lvl4 <= 4, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
